// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data_mem_resp slice: default widths, access-type
// encodings and the FSM state type.
// Configuration macro: MEM_CLEAR_EN adds the StClear state used by the
// post-reset memory sweep; without it the FSM is only StIdle/StAck.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int unsigned DEF_WORD_SIZE   = 16;
    localparam int unsigned DEF_MEMORY_ADDR = 16;

    // M_W encoding on the bus
    localparam logic M_READ  = 1'b1;
    localparam logic M_WRITE = 1'b0;

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {StClear, StIdle, StAck} state_e;
`else
    typedef enum logic [0:0] {StIdle, StAck} state_e;
`endif

endpackage

// File: rtl/data_mem_resp_if.sv
// -----------------------------------------------------------------------------
// data_mem_resp_if
// Request/response bus between an initiator and data_mem_resp.
//   MREQ     request valid, held by the initiator until MACK
//   M_W      access type (M_READ / M_WRITE)
//   MADDR    word address
//   MDATAOUT write data from the initiator
//   MDATAIN  read data returned to the initiator
//   MACK     one-cycle completion pulse
//   MERR     out-of-range flag, meaningful only with MACK
//   BUSY     no request can be accepted
// Modports: master (initiator side), slave (memory side).
// -----------------------------------------------------------------------------
interface data_mem_resp_if
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
    parameter int unsigned MEMORY_ADDR = DEF_MEMORY_ADDR
);

    logic                   MREQ;
    logic                   M_W;
    logic [MEMORY_ADDR-1:0] MADDR;
    logic [WORD_SIZE-1:0]   MDATAOUT;
    logic [WORD_SIZE-1:0]   MDATAIN;
    logic                   MACK;
    logic                   MERR;
    logic                   BUSY;

    modport master (
        output MREQ, M_W, MADDR, MDATAOUT,
        input  MDATAIN, MACK, MERR, BUSY
    );

    modport slave (
        input  MREQ, M_W, MADDR, MDATAOUT,
        output MDATAIN, MACK, MERR, BUSY
    );

endinterface

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM: one write or one registered read per cycle.
// Write has priority if both enables are high.
//   i_clk    clock
//   i_we     write enable
//   i_re     read enable (o_rdata updates on the same edge)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data, holds between reads
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
    parameter int unsigned DEPTH     = 256,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_addr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] o_rdata
);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Word memory behind a MREQ/MACK handshake. A request seen in StIdle is
// accepted on that edge; MACK pulses for the following cycle (StAck), during
// which MREQ is ignored. Reads have latency 1; writes commit at acceptance.
// Addresses >= DEPTH set MERR with MACK, read back 0 and never touch memory.
//   DCLK  clock (rising edge)
//   RSTN  asynchronous active-low reset; forces MACK/MERR/MDATAIN to 0
//   bus   data_mem_resp_if.slave (MREQ, M_W, MADDR, MDATAOUT in;
//         MDATAIN, MACK, MERR, BUSY out)
// Configuration macro: MEM_CLEAR_EN -- after reset, sweep zeros into every
// word (BUSY high for DEPTH cycles). Without it reset goes straight to idle
// and memory contents are left as they were.
// -----------------------------------------------------------------------------
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
    parameter int unsigned MEMORY_ADDR = DEF_MEMORY_ADDR,
    parameter int unsigned DEPTH       = 256
) (
    input logic            DCLK,
    input logic            RSTN,
    data_mem_resp_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e               r_state;
    logic                 r_mack;
    logic                 r_merr;
    logic                 r_busy;
    // Last completed read was out of range (or nothing read since reset)
    logic                 r_rd_zero;

    logic [MEMORY_ADDR:0] w_addr_ext;
    logic                 w_oor;
    logic                 w_accept;
    logic                 w_ram_we;
    logic                 w_ram_re;
    logic [AW-1:0]        w_ram_addr;
    logic [WORD_SIZE-1:0] w_ram_wdata;
    logic [WORD_SIZE-1:0] w_ram_rdata;

    // One extra bit so DEPTH == 2**MEMORY_ADDR still compares correctly
    assign w_addr_ext = {1'b0, bus.MADDR};
    assign w_oor      = w_addr_ext >= (MEMORY_ADDR + 1)'(DEPTH);
    assign w_accept   = (r_state == StIdle) && bus.MREQ;
    assign w_ram_re   = w_accept && (bus.M_W == M_READ) && !w_oor;

`ifdef MEM_CLEAR_EN
    logic [AW-1:0] r_clr_cnt;
    logic          w_clearing;

    assign w_clearing  = (r_state == StClear);
    assign w_ram_we    = w_clearing || (w_accept && (bus.M_W == M_WRITE) && !w_oor);
    assign w_ram_addr  = w_clearing ? r_clr_cnt : bus.MADDR[AW-1:0];
    assign w_ram_wdata = w_clearing ? '0 : bus.MDATAOUT;
`else
    assign w_ram_we    = w_accept && (bus.M_W == M_WRITE) && !w_oor;
    assign w_ram_addr  = bus.MADDR[AW-1:0];
    assign w_ram_wdata = bus.MDATAOUT;
`endif

    always_ff @(posedge DCLK or negedge RSTN) begin
        if (!RSTN) begin
`ifdef MEM_CLEAR_EN
            r_state   <= StClear;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
`else
            r_state   <= StIdle;
            r_busy    <= 1'b0;
`endif
            r_mack    <= 1'b0;
            r_merr    <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            unique case (r_state)
`ifdef MEM_CLEAR_EN
                StClear: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == AW'(DEPTH - 1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                StIdle: begin
                    if (bus.MREQ) begin
                        r_state <= StAck;
                        r_busy  <= 1'b1;
                        r_mack  <= 1'b1;
                        r_merr  <= w_oor;
                        if (bus.M_W == M_READ) begin
                            r_rd_zero <= w_oor;
                        end
                    end
                end
                StAck: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_mack  <= 1'b0;
                    r_merr  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_mack  <= 1'b0;
                    r_merr  <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem_array (
        .i_clk   (DCLK),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM output register holds across writes; the flag supplies the zero
    // for out-of-range reads and for the reset value.
    assign bus.MDATAIN = r_rd_zero ? '0 : w_ram_rdata;
    assign bus.MACK    = r_mack;
    assign bus.MERR    = r_merr;
    assign bus.BUSY    = r_busy;

endmodule
